// File: rtl/shift_add_mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shift_add_mul_ctrl
// Brief    : 32x32 unsigned shift-and-add multiplier controller. The
//            accumulation uses an external 32-bit adder.
// Revision : 1.0 - initial release
// ============================================================================
module shift_add_mul_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] mcand,
  input  logic [31:0] mplier,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_ci,
  input  logic [31:0] add_s,
  input  logic        add_co,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);

  localparam logic [4:0] c_last_iter = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_p_hi;
  logic [31:0] r_p_lo;
  logic [31:0] r_m;
  logic [4:0]  r_cnt;
  logic        r_done;
  logic        w_load;
  logic        w_busy;
  logic        w_last;

  assign w_busy = (r_state == S_BUSY);
  assign w_last = w_busy && (r_cnt == c_last_iter);
  // A new operation may begin from IDLE or directly from DONE.
  assign w_load = start && !w_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_BUSY;
      S_BUSY: if (r_cnt == c_last_iter) w_state_nxt = S_DONE;
      S_DONE: if (start) w_state_nxt = S_BUSY;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Adder operands are forced to zero outside BUSY to keep the adder quiet.
  always_comb begin
    add_a  = 32'd0;
    add_b  = 32'd0;
    add_ci = 1'b0;
    if (w_busy) begin
      add_a = r_p_hi;
      add_b = r_p_lo[0] ? r_m : 32'd0;
    end
  end

  // Each iteration shifts the 65-bit {carry, sum, P_lo} right by one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p_hi <= 32'd0;
      r_p_lo <= 32'd0;
      r_m    <= 32'd0;
      r_cnt  <= 5'd0;
    end else if (w_load) begin
      r_p_hi <= 32'd0;
      r_p_lo <= mplier;
      r_m    <= mcand;
      r_cnt  <= 5'd0;
    end else if (w_busy) begin
      r_p_hi <= {add_co, add_s[31:1]};
      r_p_lo <= {add_s[0], r_p_lo[31:1]};
      r_cnt  <= r_cnt + 5'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_last;
    end
  end

  assign busy    = w_busy;
  assign done    = r_done;
  assign product = {r_p_hi, r_p_lo};

endmodule
`default_nettype wire

// File: tb/tb_shift_add_mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_add_mul_ctrl
// Brief    : Self-checking bench for shift_add_mul_ctrl with a ripple adder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_add_mul_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_ci;
  logic [31:0] add_s;
  logic        add_co;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int checks;
  int errors;

  shift_add_mul_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mcand   (mcand),
    .mplier  (mplier),
    .add_a   (add_a),
    .add_b   (add_b),
    .add_ci  (add_ci),
    .add_s   (add_s),
    .add_co  (add_co),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  // External 32-bit ripple-carry adder
  logic [32:0] w_rc;
  assign w_rc[0] = add_ci;
  for (genvar i = 0; i < 32; i++) begin : g_fa
    assign add_s[i]  = add_a[i] ^ add_b[i] ^ w_rc[i];
    assign w_rc[i+1] = (add_a[i] & add_b[i]) | (w_rc[i] & (add_a[i] ^ add_b[i]));
  end
  assign add_co = w_rc[32];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one edge; returns just after the accepting edge E0.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    mcand  = a;
    mplier = b;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts negedge samples until done. Sample n lies in the cycle after edge
  // E(n-1), so a 32-cycle latency shows up as cycles==33. start (with the
  // given operands) is driven high during samples inj_from..inj_to.
  task automatic wait_done(input int inj_from, input int inj_to,
                           input logic [31:0] ia, input logic [31:0] ib,
                           output int cycles, output int busy_cnt);
    cycles   = 0;
    busy_cnt = 0;
    while (cycles < 100) begin
      @(negedge clk);
      cycles++;
      if (cycles >= inj_from && cycles <= inj_to) begin
        mcand  = ia;
        mplier = ib;
        start  = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) break;
      if (busy) busy_cnt++;
    end
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    mcand = 32'hdead_beef;
    mplier = 32'h1234_5678;
    repeat (2) @(negedge clk);
    checks++;
    if (product !== 64'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: product=%h busy=%b done=%b, want 0/0/0", product, busy, done);
    end
    checks++;
    if (add_a !== 32'd0 || add_b !== 32'd0 || add_ci !== 1'b0) begin
      errors++;
      $display("FAIL reset_adder: a=%h b=%h ci=%b, want 0", add_a, add_b, add_ci);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b, want 0/0", busy, done);
    end
  endtask

  task automatic test_basic;
    int cyc, bc;
    launch(32'd3, 32'd5);
    wait_done(-1, -1, 0, 0, cyc, bc);
    checks++;
    if (cyc != 33 || bc != 32) begin
      errors++;
      $display("FAIL basic_latency: cycles=%0d busy=%0d, want 33/32", cyc, bc);
    end
    checks++;
    if (product !== 64'h0000_0000_0000_000F) begin
      errors++;
      $display("FAIL basic_product: got %h want %h", product, 64'hF);
    end
    checks++;
    if (busy !== 1'b0 || add_a !== 32'd0 || add_b !== 32'd0) begin
      errors++;
      $display("FAIL done_outputs: busy=%b a=%h b=%h, want 0", busy, add_a, add_b);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || product !== 64'hF) begin
      errors++;
      $display("FAIL done_hold: done=%b busy=%b product=%h, want 0/0/f", done, busy, product);
    end
  endtask

  task automatic test_max;
    int cyc, bc;
    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(-1, -1, 0, 0, cyc, bc);
    checks++;
    if (cyc != 33 || product !== 64'hFFFF_FFFE_0000_0001) begin
      errors++;
      $display("FAIL max_product: cycles=%0d got %h want %h", cyc, product, 64'hFFFF_FFFE_0000_0001);
    end
  endtask

  task automatic test_start_ignored;
    int cyc, bc;
    launch(32'h0001_0003, 32'h0000_0107);
    wait_done(10, 10, 32'hFFFF_0000, 32'h0F0F_0F0F, cyc, bc);
    checks++;
    if (cyc != 33 || bc != 32) begin
      errors++;
      $display("FAIL ignore_latency: cycles=%0d busy=%0d, want 33/32", cyc, bc);
    end
    checks++;
    if (product !== 64'(32'h0001_0003) * 64'(32'h0000_0107)) begin
      errors++;
      $display("FAIL ignore_product: got %h want %h", product,
               64'(32'h0001_0003) * 64'(32'h0000_0107));
    end
  endtask

  task automatic test_rst_mid;
    int cyc, bc, done_seen;
    launch(32'hAAAA_5555, 32'h7777_1111);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (product !== 64'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: product=%h busy=%b done=%b, want 0/0/0", product, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      errors++;
      $display("FAIL mid_reset_no_done: done pulses=%0d want 0", done_seen);
    end
    launch(32'h1234_5678, 32'h10);
    wait_done(-1, -1, 0, 0, cyc, bc);
    checks++;
    if (cyc != 33 || product !== 64'h0000_0001_2345_6780) begin
      errors++;
      $display("FAIL post_reset_product: cycles=%0d got %h want %h", cyc, product, 64'h1_2345_6780);
    end
  endtask

  task automatic test_back_to_back;
    int cyc, bc;
    launch(32'd7, 32'd9);
    wait_done(32, 33, 32'h8000_0000, 32'd2, cyc, bc);
    checks++;
    if (cyc != 33 || product !== 64'd63) begin
      errors++;
      $display("FAIL b2b_first: cycles=%0d got %h want %h", cyc, product, 64'd63);
    end
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(-1, -1, 0, 0, cyc, bc);
    checks++;
    if (cyc != 33 || bc != 32 || product !== 64'h0000_0001_0000_0000) begin
      errors++;
      $display("FAIL b2b_second: cycles=%0d busy=%0d got %h want %h", cyc, bc, product, 64'h1_0000_0000);
    end
  endtask

  task automatic test_random;
    int cyc, bc;
    logic [31:0] a, b;
    logic [63:0] exp_p;
    for (int n = 0; n < 1000; n++) begin
      case (n)
        0: begin a = 32'd0;     b = $urandom; end
        1: begin a = $urandom;  b = 32'd0;    end
        2: begin a = 32'd1;     b = $urandom; end
        default: begin a = $urandom; b = $urandom; end
      endcase
      exp_p = 64'(a) * 64'(b);
      launch(a, b);
      wait_done(-1, -1, 0, 0, cyc, bc);
      checks++;
      if (cyc != 33 || product !== exp_p) begin
        errors++;
        $display("FAIL random_%0d: %h*%h cycles=%0d got %h want %h", n, a, b, cyc, product, exp_p);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    mcand  = 32'd0;
    mplier = 32'd0;
    test_reset;
    test_basic;
    test_max;
    test_start_ignored;
    test_rst_mid;
    test_back_to_back;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
